// File: rtl/hash_cmd_issuer_pkg.sv
// Shared opcode encodings, command word geometry and the command packer
// for the hash table command issuer.
package hash_cmd_pkg;

  localparam int OP_WIDTH    = 2;
  localparam int CMD_WIDTH   = 32;
  localparam int FIELD_WIDTH = CMD_WIDTH - OP_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_INSERT = 2'b10;
  localparam logic [OP_WIDTH-1:0] OP_LOOKUP = 2'b01;

  typedef enum logic [OP_WIDTH-1:0] {
    HOP_ILLEGAL0 = 2'b00,
    HOP_LOOKUP   = OP_LOOKUP,
    HOP_INSERT   = OP_INSERT,
    HOP_ILLEGAL3 = 2'b11
  } hash_op_t;

  // Key and data arrive zero-extended to the full field width; the key sits
  // directly above a data field that is data_width bits wide. Lookups carry
  // no payload, so their data bits are packed as zero.
  function automatic logic [CMD_WIDTH-1:0] pack_cmd(
    input hash_op_t               op,
    input logic [FIELD_WIDTH-1:0] key,
    input logic [FIELD_WIDTH-1:0] data,
    input int unsigned            data_width
  );
    logic [FIELD_WIDTH-1:0] fld;
    fld = key << data_width;
    if (op != HOP_LOOKUP) fld = fld | data;
    return {op, fld};
  endfunction

endpackage

// File: rtl/hash_cmd_issuer_if.sv
// Producer-side command fields, table-side issue handshake and debug status
// of the hash command issuer, bundled as one interface.
interface hash_cmd_issuer_if #(
  parameter int KEY_WIDTH  = 3,
  parameter int DATA_WIDTH = 27,
  parameter int FIFO_DEPTH = 4
);
  import hash_cmd_pkg::*;

  logic                          flush_i;
  logic [OP_WIDTH-1:0]           cmd_op_i;
  logic [KEY_WIDTH-1:0]          cmd_key_i;
  logic [DATA_WIDTH-1:0]         cmd_data_i;
  logic                          cmd_valid_i;
  logic                          cmd_ready_o;
  logic [CMD_WIDTH-1:0]          m_data_o;
  logic                          m_valid_o;
  logic                          m_ready_i;
  logic [$clog2(FIFO_DEPTH):0]   level_o;
  logic [15:0]                   ins_count_o;
  logic [15:0]                   lkp_count_o;
  logic [15:0]                   drop_count_o;

  // Host/table side: drives commands and the table ready, observes the rest.
  modport master (
    output flush_i, cmd_op_i, cmd_key_i, cmd_data_i, cmd_valid_i, m_ready_i,
    input  cmd_ready_o, m_data_o, m_valid_o, level_o,
           ins_count_o, lkp_count_o, drop_count_o
  );

  // Issuer side.
  modport slave (
    input  flush_i, cmd_op_i, cmd_key_i, cmd_data_i, cmd_valid_i, m_ready_i,
    output cmd_ready_o, m_data_o, m_valid_o, level_o,
           ins_count_o, lkp_count_o, drop_count_o
  );

endinterface

// File: rtl/hash_cmd_issuer_sync_cmd_fifo.sv
// Single-clock circular command buffer. Pointers carry an extra wrap bit so
// full and empty are distinguishable with every entry in use.
module sync_cmd_fifo
  import hash_cmd_pkg::*;
#(
  parameter int WIDTH = CMD_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_empty   = (r_wptr == r_rptr);
  assign o_level   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; a flush returns both pointers to zero, discarding contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/hash_cmd_issuer.sv
// Command stage ahead of the hash table: decodes and packs producer commands,
// drops illegal opcodes, buffers legal commands and counts each kind.
module hash_cmd_issuer
  import hash_cmd_pkg::*;
#(
  parameter int KEY_WIDTH  = 3,
  parameter int DATA_WIDTH = 27,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  hash_cmd_issuer_if.slave  bus
);

  if (OP_WIDTH + KEY_WIDTH + DATA_WIDTH != CMD_WIDTH) begin : g_bad_width
    $error("hash_cmd_issuer: 2 + KEY_WIDTH + DATA_WIDTH must equal 32");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hash_cmd_issuer: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  hash_op_t                  w_op;
  logic                      w_legal;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [CMD_WIDTH-1:0]      w_word;
  logic [CMD_WIDTH-1:0]      w_head;
  logic [15:0]               r_ins_cnt;
  logic [15:0]               r_lkp_cnt;
  logic [15:0]               r_drop_cnt;

  assign w_op     = hash_op_t'(bus.cmd_op_i);
  assign w_legal  = (w_op == HOP_INSERT) || (w_op == HOP_LOOKUP);
  assign w_accept = bus.cmd_valid_i && bus.cmd_ready_o;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = bus.m_valid_o && bus.m_ready_i;
  assign w_word   = pack_cmd(w_op, FIELD_WIDTH'(bus.cmd_key_i),
                             FIELD_WIDTH'(bus.cmd_data_i), DATA_WIDTH);

  // Ready depends only on registered fullness and flush, never on m_ready_i.
  assign bus.cmd_ready_o  = !w_full && !bus.flush_i;
  assign bus.m_valid_o    = !w_empty;
  assign bus.m_data_o     = w_empty ? '0 : w_head;
  assign bus.ins_count_o  = r_ins_cnt;
  assign bus.lkp_count_o  = r_lkp_cnt;
  assign bus.drop_count_o = r_drop_cnt;

  sync_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.flush_i),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (bus.level_o)
  );

  // Saturating per-type counters, bumped at the accepting edge; flush keeps them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ins_cnt  <= '0;
      r_lkp_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (w_accept) begin
      if (w_op == HOP_INSERT)      r_ins_cnt  <= sat_inc(r_ins_cnt);
      else if (w_op == HOP_LOOKUP) r_lkp_cnt  <= sat_inc(r_lkp_cnt);
      else                         r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

endmodule

// File: tb/tb_hash_cmd_issuer.sv
// Directed bench for hash_cmd_issuer with hand-computed command words.
module tb_hash_cmd_issuer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hash_cmd_issuer_if #(.KEY_WIDTH(3), .DATA_WIDTH(27), .FIFO_DEPTH(4)) bus ();

  hash_cmd_issuer #(.KEY_WIDTH(3), .DATA_WIDTH(27), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [2:0] key, input logic [26:0] data);
    bus.cmd_op_i    = op;
    bus.cmd_key_i   = key;
    bus.cmd_data_i  = data;
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(bus.m_valid_o), 32'd0);
    chk({tag, "_data"},  bus.m_data_o, 32'h0);
    chk({tag, "_level"}, 32'(bus.level_o), 32'd0);
    chk({tag, "_ins"},   32'(bus.ins_count_o), 32'd0);
    chk({tag, "_lkp"},   32'(bus.lkp_count_o), 32'd0);
    chk({tag, "_drop"},  32'(bus.drop_count_o), 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.cmd_op_i    = 2'b00;
    bus.cmd_key_i   = 3'd0;
    bus.cmd_data_i  = 27'd0;
    bus.cmd_valid_i = 1'b0;
    bus.m_ready_i   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Single insert, issued one cycle after acceptance
    push(2'b10, 3'b000, 27'd1);
    chk("ins1_valid", 32'(bus.m_valid_o), 32'd1);
    chk("ins1_data",  bus.m_data_o, 32'h80000001);
    chk("ins1_count", 32'(bus.ins_count_o), 32'd1);
    chk("ins1_level", 32'(bus.level_o), 32'd1);
    step();
    chk("ins1_drain", 32'(bus.m_valid_o), 32'd0);

    // Lookup: data field packed as zero
    push(2'b01, 3'b111, 27'h5);
    chk("lkp_data",  bus.m_data_o, 32'h78000000);
    chk("lkp_count", 32'(bus.lkp_count_o), 32'd1);
    step();
    chk("lkp_drain", 32'(bus.level_o), 32'd0);

    // Fill with table stalled
    bus.m_ready_i = 1'b0;
    push(2'b10, 3'd6, 27'd2);
    chk("fill1_level", 32'(bus.level_o), 32'd1);
    push(2'b10, 3'd1, 27'd3);
    push(2'b10, 3'd2, 27'd4);
    push(2'b10, 3'd5, 27'h7FFFFFF);
    chk("full_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("full_level", 32'(bus.level_o), 32'd4);
    chk("full_head",  bus.m_data_o, 32'hB0000002);

    // Fifth command waits while full
    bus.cmd_op_i    = 2'b10;
    bus.cmd_key_i   = 3'd3;
    bus.cmd_data_i  = 27'd9;
    bus.cmd_valid_i = 1'b1;
    step();
    chk("hold_level", 32'(bus.level_o), 32'd4);
    chk("hold_ins",   32'(bus.ins_count_o), 32'd5);
    chk("hold_head",  bus.m_data_o, 32'hB0000002);
    bus.m_ready_i = 1'b1;
    #1;
    chk("full_pop_ready", 32'(bus.cmd_ready_o), 32'd0);
    step();
    chk("drain1_level", 32'(bus.level_o), 32'd3);
    chk("drain1_data",  bus.m_data_o, 32'h88000003);
    chk("drain1_ready", 32'(bus.cmd_ready_o), 32'd1);
    step();
    bus.cmd_valid_i = 1'b0;
    chk("pushpop_level", 32'(bus.level_o), 32'd3);
    chk("pushpop_data",  bus.m_data_o, 32'h90000004);
    chk("pushpop_ins",   32'(bus.ins_count_o), 32'd6);
    step();
    chk("drain3_data", bus.m_data_o, 32'hAFFFFFFF);
    step();
    chk("drain4_data", bus.m_data_o, 32'h98000009);
    step();
    chk("drain_empty", 32'(bus.m_valid_o), 32'd0);
    chk("drain_zero",  bus.m_data_o, 32'h0);

    // Illegal opcodes complete the handshake but enqueue nothing
    bus.cmd_op_i    = 2'b11;
    bus.cmd_valid_i = 1'b1;
    #1;
    chk("ill_ready", 32'(bus.cmd_ready_o), 32'd1);
    step();
    bus.cmd_op_i = 2'b00;
    step();
    bus.cmd_valid_i = 1'b0;
    chk("drop_count", 32'(bus.drop_count_o), 32'd2);
    chk("drop_level", 32'(bus.level_o), 32'd0);
    chk("drop_valid", 32'(bus.m_valid_o), 32'd0);
    chk("drop_ins",   32'(bus.ins_count_o), 32'd6);
    chk("drop_lkp",   32'(bus.lkp_count_o), 32'd1);

    // Flush with a command offered in the same cycle
    bus.m_ready_i = 1'b0;
    push(2'b10, 3'd0, 27'd1);
    push(2'b10, 3'd0, 27'd2);
    push(2'b10, 3'd0, 27'd3);
    chk("pre_flush_level", 32'(bus.level_o), 32'd3);
    bus.flush_i     = 1'b1;
    bus.cmd_op_i    = 2'b10;
    bus.cmd_data_i  = 27'd4;
    bus.cmd_valid_i = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.cmd_ready_o), 32'd0);
    step();
    bus.flush_i     = 1'b0;
    bus.cmd_valid_i = 1'b0;
    chk("flush_level", 32'(bus.level_o), 32'd0);
    chk("flush_valid", 32'(bus.m_valid_o), 32'd0);
    chk("flush_data",  bus.m_data_o, 32'h0);
    chk("flush_ins",   32'(bus.ins_count_o), 32'd9);

    // Asynchronous reset mid-stream
    push(2'b10, 3'd4, 27'd7);
    push(2'b01, 3'd2, 27'd0);
    chk("prerst_level", 32'(bus.level_o), 32'd2);
    chk("prerst_head",  bus.m_data_o, 32'hA0000007);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
